// File: rtl/mem_access_unit_if.sv
// Bundle of EX/MEM inputs, data-memory bus and MEM/WB outputs for mem_access_unit.
// slave is the unit's view; master is the surrounding pipeline/memory view.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  // EX/MEM side
  logic              in_valid;
  logic              in_mem_rd;
  logic              in_mem_wr;
  logic [1:0]        in_size;
  logic              in_signed;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;
  logic [31:0]       in_alu;
  logic [4:0]        in_rd;
  logic              in_reg_write;
  logic              flush;
  logic              stall;

  // Data-memory side
  logic [31:0]       dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic              dm_length;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;

  // MEM/WB side
  logic              wb_valid;
  logic [31:0]       wb_data;
  logic [4:0]        wb_rd;
  logic              wb_reg_write;
  logic              excp;
  logic [31:0]       excp_addr;

  modport slave (
    input  in_valid, in_mem_rd, in_mem_wr, in_size, in_signed, in_addr, in_wdata, in_alu,
    input  in_rd, in_reg_write, flush, dm_rdata,
    output stall, dm_addr, dm_rd, dm_wr, dm_length, dm_wdata,
    output wb_valid, wb_data, wb_rd, wb_reg_write, excp, excp_addr
  );

  modport master (
    output in_valid, in_mem_rd, in_mem_wr, in_size, in_signed, in_addr, in_wdata, in_alu,
    output in_rd, in_reg_write, flush, dm_rdata,
    input  stall, dm_addr, dm_rd, dm_wr, dm_length, dm_wdata,
    input  wb_valid, wb_data, wb_rd, wb_reg_write, excp, excp_addr
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit for a big-endian, word-write-only data memory; sb/sh use RMW.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of silently aligning them.
module mem_access_unit #(
  parameter int unsigned DM_BYTES = 128,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus_io
);

  typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

  localparam logic [ADDR_W:0] DmLimit = (ADDR_W+1)'(DM_BYTES);

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        excp_q, excp_d;
  logic [31:0] excp_addr_q, excp_addr_d;

  logic              act, is_mem, is_store, is_load;
  logic              sz_byte, sz_half, sz_word;
  logic [1:0]        span;
  logic [ADDR_W-1:0] addr_eff;
  logic [ADDR_W:0]   last_byte;
  logic              misal, oor, fault;
  logic [31:0]       addr32, base32;
  logic [1:0]        lane;
  logic [7:0]        rd_byte;
  logic [31:0]       load_val, merged;

  logic        stall, dm_rd, dm_wr, dm_length;
  logic [31:0] dm_addr, dm_wdata;

  // Request decode, alignment and range checks
  always_comb begin
    act      = bus_io.in_valid & ~bus_io.flush;
    is_mem   = bus_io.in_mem_rd | bus_io.in_mem_wr;
    is_store = bus_io.in_mem_wr;
    is_load  = bus_io.in_mem_rd & ~bus_io.in_mem_wr;
    sz_byte  = (bus_io.in_size == 2'd0);
    sz_half  = (bus_io.in_size == 2'd1);
    sz_word  = bus_io.in_size[1];
    span     = sz_word ? 2'd3 : (sz_half ? 2'd1 : 2'd0);
    addr_eff = bus_io.in_addr;
`ifdef MISALIGN_TRAP_EN
    misal = (sz_half & bus_io.in_addr[0]) | (sz_word & (|bus_io.in_addr[1:0]));
`else
    misal = 1'b0;
    if (sz_half) addr_eff[0] = 1'b0;
    if (sz_word) addr_eff[1:0] = 2'b00;
`endif
    last_byte = {1'b0, addr_eff} + {{(ADDR_W-1){1'b0}}, span};
    oor       = (last_byte >= DmLimit);
    fault     = is_mem & (misal | oor);
    addr32    = 32'(addr_eff);
    base32    = {addr32[31:2], 2'b00};
    lane      = addr_eff[1:0];
  end

  // Sub-word extraction and store-lane merge; lane 0 is the most significant byte
  always_comb begin
    rd_byte = 8'h00;
    unique case (lane)
      2'd0: rd_byte = bus_io.dm_rdata[31:24];
      2'd1: rd_byte = bus_io.dm_rdata[23:16];
      2'd2: rd_byte = bus_io.dm_rdata[15:8];
      2'd3: rd_byte = bus_io.dm_rdata[7:0];
      default: rd_byte = 8'h00;
    endcase

    if (sz_word) begin
      load_val = bus_io.dm_rdata;
    end else if (sz_half) begin
      load_val = {{16{bus_io.in_signed & bus_io.dm_rdata[15]}}, bus_io.dm_rdata[15:0]};
    end else begin
      load_val = {{24{bus_io.in_signed & rd_byte[7]}}, rd_byte};
    end

    merged = bus_io.dm_rdata;
    if (sz_half) begin
      if (lane[1]) merged[15:0] = bus_io.in_wdata[15:0];
      else         merged[31:16] = bus_io.in_wdata[15:0];
    end else begin
      unique case (lane)
        2'd0: merged[31:24] = bus_io.in_wdata[7:0];
        2'd1: merged[23:16] = bus_io.in_wdata[7:0];
        2'd2: merged[15:8]  = bus_io.in_wdata[7:0];
        2'd3: merged[7:0]   = bus_io.in_wdata[7:0];
        default: merged = bus_io.dm_rdata;
      endcase
    end
  end

  // Next-state and memory-side outputs
  always_comb begin
    state_d        = state_q;
    merge_d        = merge_q;
    rmw_addr_d     = rmw_addr_q;
    wb_valid_d     = 1'b0;
    wb_data_d      = wb_data_q;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = 1'b0;
    excp_d         = 1'b0;
    excp_addr_d    = excp_addr_q;
    stall          = 1'b0;
    dm_rd          = 1'b0;
    dm_wr          = 1'b0;
    dm_length      = 1'b0;
    dm_addr        = 32'h0;
    dm_wdata       = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (act) begin
          wb_rd_d = bus_io.in_rd;
          if (fault) begin
            wb_valid_d  = 1'b1;
            excp_d      = 1'b1;
            excp_addr_d = 32'(bus_io.in_addr);
          end else if (is_store) begin
            if (sz_word) begin
              dm_wr      = 1'b1;
              dm_addr    = addr32;
              dm_wdata   = bus_io.in_wdata;
              wb_valid_d = 1'b1;
            end else begin
              stall      = 1'b1;
              dm_rd      = 1'b1;
              dm_addr    = base32;
              merge_d    = merged;
              rmw_addr_d = base32;
              state_d    = StRmwWr;
            end
          end else if (is_load) begin
            dm_rd          = 1'b1;
            dm_length      = sz_half;
            dm_addr        = sz_byte ? base32 : addr32;
            wb_valid_d     = 1'b1;
            wb_data_d      = load_val;
            wb_reg_write_d = bus_io.in_reg_write;
          end else begin
            wb_valid_d     = 1'b1;
            wb_data_d      = bus_io.in_alu;
            wb_reg_write_d = bus_io.in_reg_write;
          end
        end
      end
      StRmwWr: begin
        // The write is already committed; flush and the presented instruction are ignored.
        dm_wr      = 1'b1;
        dm_addr    = rmw_addr_q;
        dm_wdata   = merge_q;
        wb_valid_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Reset must suppress a pending RMW write in the same cycle.
    if (rst) begin
      stall     = 1'b0;
      dm_rd     = 1'b0;
      dm_wr     = 1'b0;
      dm_length = 1'b0;
      dm_addr   = 32'h0;
      dm_wdata  = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      merge_q        <= 32'h0;
      rmw_addr_q     <= 32'h0;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= 32'h0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      excp_q         <= 1'b0;
      excp_addr_q    <= 32'h0;
    end else begin
      state_q        <= state_d;
      merge_q        <= merge_d;
      rmw_addr_q     <= rmw_addr_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      excp_q         <= excp_d;
      excp_addr_q    <= excp_addr_d;
    end
  end

  assign bus_io.stall        = stall;
  assign bus_io.dm_addr      = dm_addr;
  assign bus_io.dm_rd        = dm_rd;
  assign bus_io.dm_wr        = dm_wr;
  assign bus_io.dm_length    = dm_length;
  assign bus_io.dm_wdata     = dm_wdata;
  assign bus_io.wb_valid     = wb_valid_q;
  assign bus_io.wb_data      = wb_data_q;
  assign bus_io.wb_rd        = wb_rd_q;
  assign bus_io.wb_reg_write = wb_reg_write_q;
  assign bus_io.excp         = excp_q;
  assign bus_io.excp_addr    = excp_addr_q;

endmodule
